regfile_mp: RTL
===============

// Module: regfile_mp
// PURPOSE
//   Parametrised multi-port register file: NUM_REGS x DATA_W storage, NUM_RD read ports, two write ports.
//   Write ports support per-byte enables.
//   Options: write-to-read bypass, registered read, hardwired zero register 0.
//   Datapath register file for the small-core blocks; replaces the fixed 4x32, 2R/1W file.
// PARAMETERS
//   DATA_W     32  data width in bits; must be a multiple of 8
//   NUM_REGS   4   number of registers, >= 2 (need not be a power of 2)
//   NUM_RD     2   number of read ports, 1..8
//   READ_LAT   0   0 = combinational read, 1 = read data registered on posedge clk
//   BYPASS     1   1 = same-cycle write data is forwarded to matching reads
//   ZERO_REG0  0   1 = register 0 always reads 0 and ignores writes
//   RESET_VAL  0   DATA_W-bit value loaded into every register on reset
//   AW = $clog2(NUM_REGS) (localparam); BE_W = DATA_W/8 (localparam)
// PORTS
//   clk        in   1              clock; all state updates on posedge
//   reset      in   1              asynchronous active-low reset
//   ReadReg    in   NUM_RD*AW      read addresses; port i at [i*AW +: AW]
//   ReadData   out  NUM_RD*DATA_W  read data; port i at [i*DATA_W +: DATA_W]
//   RegWrite0  in   1              write enable, port 0
//   WriteReg0  in   AW             write address, port 0
//   WriteData0 in   DATA_W         write data, port 0
//   ByteEn0    in   BE_W           byte enables, port 0; bit b covers bits [8b+7:8b]
//   RegWrite1  in   1              write enable, port 1
//   WriteReg1  in   AW             write address, port 1
//   WriteData1 in   DATA_W         write data, port 1
//   ByteEn1    in   BE_W           byte enables, port 1; bit b covers bits [8b+7:8b]
// BEHAVIOUR
//   Reset (reset=0, async, no clk needed): every register <= RESET_VAL.
//     Register 0 is excluded when ZERO_REG0=1.
//     READ_LAT=1: ReadData <= 0 at reset.
//     READ_LAT=0: ReadData follows the reset array combinationally.
//   Writes: on posedge, when RegWrite=1 and WriteReg < NUM_REGS, each byte with ByteEn=1 is updated.
//     Bytes with ByteEn=0 hold their value.
//   Ignored writes: WriteReg >= NUM_REGS, writes to register 0 when ZERO_REG0=1, and ByteEn=0 are no-ops.
//   Collision (both ports enabled, same address):
//     port 1 wins each byte where ByteEn1=1;
//     otherwise port 0 supplies that byte where ByteEn0=1;
//     otherwise the old byte holds.
//   Merged next value nxt[a]: the post-edge contents of register a under the write/collision rules above.
//   Read, READ_LAT=0, latency 0:
//     ReadData_i = nxt[ReadReg_i] if BYPASS=1 and any write enable targets ReadReg_i this cycle;
//     otherwise arr[ReadReg_i].
//   Read, READ_LAT=1, latency 1:
//     on posedge, ReadData_i <= (BYPASS ? nxt[ReadReg_i] : arr[ReadReg_i]) using the pre-edge address.
//   Out-of-range read address (>= NUM_REGS): ReadData_i = 0.
//     Register 0 reads 0 when ZERO_REG0=1.
//     Both rules take precedence over bypass.
//   Read ports are independent; any number of ports may read the same address simultaneously.
//   Reset mid-operation: an asserted reset overrides any write in the same cycle.
//     The first write takes effect on the first posedge after reset deasserts.
//   No X propagation: with all inputs known, outputs are known.
// TESTING
//   T1 reset: reset=0 with RESET_VAL=32'h0 -> all ReadData=0.
//      Assert reset mid-stream after a write -> register returns to RESET_VAL with no clk edge.
//   T2 fill/readback: write regs 0..3 = ABABABAB, BCBCBCBC, CDCDCDCD, DEDEDEDE via port 0, ByteEn=4'hF.
//      ReadReg pairs (0,1), (1,2), (2,3) -> matching data; READ_LAT=1 data is one cycle later.
//   T3 byte enables: reg1=BCBCBCBC, then write 11223344 with ByteEn=4'b0101 -> reg1 reads BC22BC44.
//   T4 collision: both ports write reg2; port0 AAAAAAAA with BE 4'hF, port1 55555555 with BE 4'b0011
//      -> reg2=AAAA5555.
//   T5 bypass: READ_LAT=0, BYPASS=1; read reg3 while writing 12345678 to it
//      -> same-cycle ReadData=12345678.
//      With BYPASS=0 the same stimulus -> old value DEDEDEDE, new value on the next cycle.
//   T6 zero reg / range: ZERO_REG0=1, write FFFFFFFF to reg0 -> reads 0.
//      NUM_REGS=5, write/read address 7 -> write ignored, read returns 0.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_REGS x DATA_W, NUM_RD read ports, two byte-enabled write ports.
// Optional write-to-read bypass, registered read data and hardwired-zero register 0.
module regfile_mp #(
    parameter int unsigned        DATA_W    = 32,
    parameter int unsigned        NUM_REGS  = 4,
    parameter int unsigned        NUM_RD    = 2,
    parameter int unsigned        READ_LAT  = 0,
    parameter int unsigned        BYPASS    = 1,
    parameter int unsigned        ZERO_REG0 = 0,
    parameter logic [DATA_W-1:0]  RESET_VAL = '0,
    localparam int unsigned       AW        = $clog2(NUM_REGS),
    localparam int unsigned       BE_W      = DATA_W / 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*AW-1:0]     ReadReg,
    output logic [NUM_RD*DATA_W-1:0] ReadData,
    input  logic                     RegWrite0,
    input  logic [AW-1:0]            WriteReg0,
    input  logic [DATA_W-1:0]        WriteData0,
    input  logic [BE_W-1:0]          ByteEn0,
    input  logic                     RegWrite1,
    input  logic [AW-1:0]            WriteReg1,
    input  logic [DATA_W-1:0]        WriteData1,
    input  logic [BE_W-1:0]          ByteEn1
);

    // Elaboration-time parameter sanity checks
    if (DATA_W == 0 || (DATA_W % 8) != 0) begin : g_chk_dw
        $error("regfile_mp: DATA_W must be a non-zero multiple of 8");
    end
    if (NUM_REGS < 2) begin : g_chk_nr
        $error("regfile_mp: NUM_REGS must be at least 2");
    end
    if (NUM_RD < 1 || NUM_RD > 8) begin : g_chk_rd
        $error("regfile_mp: NUM_RD must be in 1..8");
    end
    if (READ_LAT > 1) begin : g_chk_lat
        $error("regfile_mp: READ_LAT must be 0 or 1");
    end

    logic [DATA_W-1:0] r_arr    [NUM_REGS];
    logic [DATA_W-1:0] w_nxt    [NUM_REGS];
    logic [DATA_W-1:0] w_rd_sel [NUM_RD];
    logic              w_we0;
    logic              w_we1;

    // An asserted reset suppresses writes, and therefore bypass as well
    assign w_we0 = RegWrite0 & reset;
    assign w_we1 = RegWrite1 & reset;

    // Post-edge contents of every register; port 1 wins per byte on a collision
    always_comb begin
        for (int unsigned a = 0; a < NUM_REGS; a++) begin
            w_nxt[a] = r_arr[a];
            if (ZERO_REG0 == 0 || a != 0) begin
                for (int unsigned b = 0; b < BE_W; b++) begin
                    if (w_we1 && (WriteReg1 == AW'(a)) && ByteEn1[b]) begin
                        w_nxt[a][8*b +: 8] = WriteData1[8*b +: 8];
                    end else if (w_we0 && (WriteReg0 == AW'(a)) && ByteEn0[b]) begin
                        w_nxt[a][8*b +: 8] = WriteData0[8*b +: 8];
                    end
                end
            end
        end
    end

    // Storage array; register 0 is held at zero when it is hardwired
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned a = 0; a < NUM_REGS; a++) begin
                r_arr[a] <= (ZERO_REG0 != 0 && a == 0) ? '0 : RESET_VAL;
            end
        end else begin
            for (int unsigned a = 0; a < NUM_REGS; a++) begin
                r_arr[a] <= w_nxt[a];
            end
        end
    end

    // Per-port read select; out-of-range and hardwired-zero addresses default to 0
    always_comb begin
        logic [AW-1:0] w_addr;
        logic          w_hit;
        for (int unsigned p = 0; p < NUM_RD; p++) begin
            w_addr      = ReadReg[p*AW +: AW];
            w_hit       = (w_we0 && (WriteReg0 == w_addr)) || (w_we1 && (WriteReg1 == w_addr));
            w_rd_sel[p] = '0;
            for (int unsigned a = 0; a < NUM_REGS; a++) begin
                if ((w_addr == AW'(a)) && (ZERO_REG0 == 0 || a != 0)) begin
                    w_rd_sel[p] = (BYPASS != 0 && w_hit) ? w_nxt[a] : r_arr[a];
                end
            end
        end
    end

    if (READ_LAT == 0) begin : g_rd_comb
        always_comb begin
            ReadData = '0;
            for (int unsigned p = 0; p < NUM_RD; p++) begin
                ReadData[p*DATA_W +: DATA_W] = w_rd_sel[p];
            end
        end
    end else begin : g_rd_reg
        logic [NUM_RD*DATA_W-1:0] r_rd;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_rd <= '0;
            end else begin
                for (int unsigned p = 0; p < NUM_RD; p++) begin
                    r_rd[p*DATA_W +: DATA_W] <= w_rd_sel[p];
                end
            end
        end

        assign ReadData = r_rd;
    end

endmodule
